// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot blanking gap,
// frame-synchronous value update and optional leading-zero suppression.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter int unsigned LZ_BLANK     = 1
) (
   input  logic                      CLOCK_50,
   input  logic                      reset_n,
   input  logic [4*NUM_DIGITS-1:0]   i_value,
   input  logic                      i_load,
   input  logic                      i_enable,
   output logic [6:0]                o_seg,
   output logic [NUM_DIGITS-1:0]     o_dig,
   output logic                      o_frame
);

   localparam int unsigned P_W   = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [P_W-1:0]   P_LAST   = P_W'(SCAN_DIV - 1);
   localparam logic [P_W-1:0]   P_BLANK  = P_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [P_W-1:0]            p_q, p_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0]   display_q, display_d;
   logic [6:0]                seg_q, seg_d;
   logic [NUM_DIGITS-1:0]     dig_q, dig_d;
   logic                      frame_q, frame_d;

   logic                      p_last, wrap, show, lz_dark, above_zero;
   logic [3:0]                nib;

   function automatic logic [6:0] enc(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h7E;
         4'h1: s = 7'h30;
         4'h2: s = 7'h6D;
         4'h3: s = 7'h79;
         4'h4: s = 7'h33;
         4'h5: s = 7'h5B;
         4'h6: s = 7'h5F;
         4'h7: s = 7'h70;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h7B;
         4'hA: s = 7'h77;
         4'hB: s = 7'h1F;
         4'hC: s = 7'h4E;
         4'hD: s = 7'h3D;
         4'hE: s = 7'h4F;
         default: s = 7'h47;
      endcase
      return s;
   endfunction

   always_comb begin
      p_last    = (p_q == P_LAST);
      wrap      = p_last && (idx_q == IDX_LAST);
      p_d       = p_last ? '0 : p_q + P_W'(1);
      idx_d     = idx_q;
      if (p_last) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      pending_d = i_load ? i_value : pending_q;
      // pending_d already carries i_value when a load coincides with the wrap
      display_d = wrap ? pending_d : display_q;
      frame_d   = wrap;
   end

   // Outputs are computed from next-state so the registered pins line up with p_q/idx_q.
   always_comb begin
      nib        = '0;
      lz_dark    = 1'b0;
      above_zero = 1'b1;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         above_zero = above_zero && (display_d[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
         if (idx_d == IDX_W'(NUM_DIGITS - 1 - j)) begin
            nib     = display_d[4*(NUM_DIGITS-1-j) +: 4];
            lz_dark = (LZ_BLANK != 0) && (j != NUM_DIGITS - 1) && above_zero;
         end
      end
      show  = i_enable && (p_d >= P_BLANK) && !lz_dark;
      seg_d = show ? ~enc(nib) : 7'h7F;
      dig_d = '1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         dig_d[k] = !(show && (idx_d == IDX_W'(k)));
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         p_q       <= '0;
         idx_q     <= '0;
         pending_q <= '0;
         display_q <= '0;
         seg_q     <= 7'h7F;
         dig_q     <= '1;
         frame_q   <= 1'b0;
      end else begin
         p_q       <= p_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         display_q <= display_d;
         seg_q     <= seg_d;
         dig_q     <= dig_d;
         frame_q   <= frame_d;
      end
   end

   assign o_seg   = seg_q;
   assign o_dig   = dig_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a cycle-count reference model queues expected pin values,
// a negedge monitor pops and compares for an LZ_BLANK=1 and an LZ_BLANK=0 instance.
module tb_seg7_scan_driver;

   localparam int ND    = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = ND * DIV;

   logic        CLOCK_50;
   logic        reset_n;
   logic [15:0] i_value;
   logic        i_load;
   logic        i_enable;
   logic [6:0]  seg_a, seg_b;
   logic [3:0]  dig_a, dig_b;
   logic        frame_a, frame_b;

   int errors = 0;
   int checks = 0;

   seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(1)) dut_a (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .i_value(i_value), .i_load(i_load),
      .i_enable(i_enable), .o_seg(seg_a), .o_dig(dig_a), .o_frame(frame_a));

   seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(0)) dut_b (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .i_value(i_value), .i_load(i_load),
      .i_enable(i_enable), .o_seg(seg_b), .o_dig(dig_b), .o_frame(frame_b));

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic [6:0] seg_a;
      logic [3:0] dig_a;
      logic [6:0] seg_b;
      logic [3:0] dig_b;
      logic       frame;
   } exp_t;

   exp_t sb[$];

   logic [6:0] ENC [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   // reference state: cycles since reset release, plus the two value registers
   int          n = 0;
   logic [15:0] m_pend = '0;
   logic [15:0] m_disp = '0;

   function automatic logic [10:0] ref_pins(input logic [15:0] disp, input int t,
                                            input logic en, input bit lz);
      int         p, idx;
      logic [3:0] d;
      bit         dark;
      p    = t % DIV;
      idx  = (t / DIV) % ND;
      d    = 4'((disp >> (4 * idx)) & 16'hF);
      dark = !en || (p < BLANK) || (lz && idx > 0 && (disp >> (4 * idx)) == 0);
      if (dark) return {7'h7F, 4'hF};
      return {~ENC[d], 4'(~(1 << idx))};
   endfunction

   always @(posedge CLOCK_50) begin
      exp_t e;
      if (!reset_n) begin
         n      = 0;
         m_pend = '0;
         m_disp = '0;
         e      = '{7'h7F, 4'hF, 7'h7F, 4'hF, 1'b0};
      end else begin
         n = n + 1;
         if (n % FRAME == 0) m_disp = i_load ? i_value : m_pend;
         if (i_load) m_pend = i_value;
         {e.seg_a, e.dig_a} = ref_pins(m_disp, n, i_enable, 1'b1);
         {e.seg_b, e.dig_b} = ref_pins(m_disp, n, i_enable, 1'b0);
         e.frame = (n % FRAME == 0);
      end
      sb.push_back(e);
   end

   always @(negedge CLOCK_50) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if ({seg_a, dig_a, frame_a} !== {e.seg_a, e.dig_a, e.frame}) begin
            errors++;
            $display("FAIL lz1_pins n=%0d: got seg=%h dig=%h frame=%b, want seg=%h dig=%h frame=%b",
                     n, seg_a, dig_a, frame_a, e.seg_a, e.dig_a, e.frame);
         end
         checks++;
         if ({seg_b, dig_b, frame_b} !== {e.seg_b, e.dig_b, e.frame}) begin
            errors++;
            $display("FAIL lz0_pins n=%0d: got seg=%h dig=%h frame=%b, want seg=%h dig=%h frame=%b",
                     n, seg_b, dig_b, frame_b, e.seg_b, e.dig_b, e.frame);
         end
      end
   end

   task automatic cyc();
      @(negedge CLOCK_50);
      #1;
   endtask

   task automatic run(input int c);
      repeat (c) cyc();
   endtask

   task automatic wait_phase(input int t);
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (n % FRAME == t) return;
         cyc();
      end
      checks++;
      errors++;
      $display("FAIL wait_phase: got no phase match, want phase %0d", t);
   endtask

   task automatic load(input logic [15:0] v);
      i_value = v;
      i_load  = 1'b1;
      cyc();
      i_load  = 1'b0;
   endtask

   task automatic check_dark(input string name);
      checks++;
      if ({seg_a, dig_a, frame_a, seg_b, dig_b, frame_b} !== {7'h7F, 4'hF, 1'b0, 7'h7F, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL %s: got a=%h/%h/%b b=%h/%h/%b, want 7f/f/0 on both",
                  name, seg_a, dig_a, frame_a, seg_b, dig_b, frame_b);
      end
   endtask

   initial begin
      logic [15:0] masks [4];
      masks    = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
      reset_n  = 1'b0;
      i_value  = '0;
      i_load   = 1'b0;
      i_enable = 1'b1;
      run(3);
      check_dark("reset_state");
      reset_n = 1'b1;
      run(70);

      wait_phase(10);
      load(16'h12AF);
      run(80);

      load(16'h0005);
      run(70);

      wait_phase(3);
      load(16'h1111);
      wait_phase(20);
      load(16'h2222);
      run(40);
      wait_phase(31);
      load(16'h3333);
      run(40);

      load(16'h0F00);
      run(40);
      wait_phase(2 * DIV + 5);
      reset_n = 1'b0;
      #1;
      check_dark("async_reset");
      run(3);
      reset_n = 1'b1;
      run(40);

      load(16'h4321);
      run(40);
      i_enable = 1'b0;
      run(40);
      i_enable = 1'b1;
      run(40);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(15) == 0) begin
            i_value = 16'($urandom) & masks[$urandom_range(3)];
            i_load  = 1'b1;
         end else begin
            i_load  = 1'b0;
         end
         if ($urandom_range(39) == 0) i_enable = ~i_enable;
         cyc();
      end
      i_load = 1'b0;
      run(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
